// File: rtl/sort_checker.sv
// Post-sort verification stage: scans a 2^AW-word memory through an asynchronous read port.
// Reports order violations, the first violating index, and the min/max words.
module sort_checker #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 16,
    parameter int unsigned SIGNED_CMP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] err_cnt,
    output logic [AW-1:0] first_err,
    output logic [DW-1:0] min_val,
    output logic [DW-1:0] max_val
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    localparam logic [AW-1:0] LastAddr = '1;

    state_e        state_q;
    logic [DW-1:0] prev_q;
    logic          err_seen_q;

    logic          inversion;
    logic          new_min;
    logic          new_max;
    logic [AW-1:0] err_cnt_d;

    function automatic logic less_than(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (SIGNED_CMP != 0) begin
            return $signed(a) < $signed(b);
        end
        return a < b;
    endfunction

    // Word 0 has no predecessor, so no inversion can be counted there.
    always_comb begin
        inversion = (rd_addr != '0) && less_than(rd_data, prev_q);
        new_min   = less_than(rd_data, min_val);
        new_max   = less_than(max_val, rd_data);
        err_cnt_d = err_cnt + {{(AW-1){1'b0}}, inversion};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            prev_q     <= '0;
            err_seen_q <= 1'b0;
            rd_addr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_err  <= '0;
            min_val    <= '0;
            max_val    <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StScan;
                        busy       <= 1'b1;
                        err_cnt    <= '0;
                        first_err  <= '0;
                        pass       <= 1'b0;
                        err_seen_q <= 1'b0;
                        rd_addr    <= '0;
                    end
                end
                StScan: begin
                    prev_q  <= rd_data;
                    err_cnt <= err_cnt_d;
                    if (rd_addr == '0) begin
                        min_val <= rd_data;
                        max_val <= rd_data;
                    end else begin
                        if (new_min) min_val <= rd_data;
                        if (new_max) max_val <= rd_data;
                    end
                    if (inversion && !err_seen_q) begin
                        first_err  <= rd_addr - 1'b1;
                        err_seen_q <= 1'b1;
                    end
                    if (rd_addr == LastAddr) begin
                        state_q <= StDone;
                        rd_addr <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_cnt_d == '0);
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/sort_checker.md
Name: sort_checker

Overview:
- Downstream verification stage for the 256x16 sort engine.
- On a start pulse, normally tied to the sorter's busy falling edge, it scans the whole result memory through an asynchronous read port.
- Checks that the data is in ascending order, counts adjacent-pair inversions, records the first violation, and captures the min and max values.
- Results drive board LEDs and the 7-seg display mux, alongside the sorter's cycle counter.

Parameters:
- AW, 8: address width; the scan covers N = 2^AW words.
- DW, 16: data word width.
- SIGNED_CMP, 0: 0 = unsigned compare; 1 = two's-complement compare. Applies to both the order check and min/max.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that requests a scan.
- rd_addr  out  AW  read address to the memory's read port.
- rd_data  in  DW  read data; combinational (same-cycle) function of rd_addr, as with distributed RAM dpra/dpo.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when results are valid.
- pass  out  1  1 = memory is non-decreasing; valid from done until the next start.
- err_cnt  out  AW  number of indices i in 0..N-2 with mem[i] > mem[i+1].
- first_err  out  AW  smallest such i; 0 when err_cnt == 0.
- min_val  out  DW  minimum word in the memory.
- max_val  out  DW  maximum word in the memory.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal prev register 0.
- States and transitions:
  - IDLE -> SCAN when start = 1.
  - SCAN -> DONE on the cycle with rd_addr == N-1.
  - DONE -> IDLE unconditionally after one cycle.
- IDLE:
  - rd_addr held at 0, busy = 0.
  - When start is sampled:
    - busy <= 1.
    - err_cnt, first_err, pass cleared to 0.
    - An internal err_seen flag is cleared.
    - rd_addr stays 0.
- SCAN (one word per cycle; rd_data sampled at the clock edge ending the cycle):
  - rd_addr == 0: prev <= rd_data, min_val <= rd_data, max_val <= rd_data. No comparison is made.
  - rd_addr > 0:
    - If prev > rd_data (per SIGNED_CMP): err_cnt <= err_cnt + 1.
    - If that is the first violation (err_seen = 0): first_err <= rd_addr - 1 and err_seen <= 1.
    - min_val / max_val update when rd_data is strictly less / strictly greater.
    - prev <= rd_data.
  - Equal adjacent words are not errors.
  - rd_addr increments each cycle. On the cycle it is N-1, that last word is processed and the state goes to DONE.
  - rd_addr then returns to 0. There is no wrap past N-1 and no re-read.
- DONE:
  - done = 1 for exactly one cycle.
  - busy = 0 from the DONE cycle onward.
  - pass = 1 iff err_cnt == 0, registered and valid in the DONE cycle.
- Latency: a start sampled at edge E0 gives N SCAN cycles; done is high in the cycle after edge E0+N (N+1 cycles after the start edge). With AW = 8 this is 257 cycles.
- Width: err_cnt maximum is N-1, which fits in AW bits, so no saturation logic is needed.
- Boundary conditions:
  - start while busy or in DONE is ignored, with no restart.
  - rst mid-scan returns immediately to IDLE with all outputs 0; no done pulse is emitted.
  - Results (err_cnt, first_err, min_val, max_val, pass) hold after done until the next accepted start.
  - Memory contents must not change during the scan; this is the integrator's responsibility.

Test Plan:
- Memory mem[i] = i: pulse start -> busy high for 256 cycles, done at cycle 257, pass = 1, err_cnt = 0, first_err = 0, min_val = 0x0000, max_val = 0x00FF.
- Memory mem[i] = 0xFFFF - i (descending) -> pass = 0, err_cnt = 255 (0xFF), first_err = 0, min_val = 0xFF00, max_val = 0xFFFF.
- Ascending memory with mem[100] = 0xFFFF and mem[200] = 0x0000 -> err_cnt = 2, first_err = 100, min_val = 0x0000, max_val = 0xFFFF.
- All words 0x1234 -> pass = 1, err_cnt = 0, min_val = max_val = 0x1234.
- SIGNED_CMP = 1 with mem[0] = 0x8000 followed by ascending positive values -> pass = 1, min_val = 0x8000.
- SIGNED_CMP = 0 with the same memory -> err_cnt = 1, first_err = 0.
- Start re-pulsed at scan cycle 50 -> ignored, done still at cycle 257.
- rst asserted at scan cycle 120 -> all outputs 0 immediately, no done pulse.
- A new start after reset -> a full 257-cycle scan.
